// File: rtl/pll_pkg.sv
// Shared types and helpers for the sampled phase-frequency detector.
package pll_pkg;

    typedef enum logic [1:0] {
        PFD_IDLE,
        PFD_UP,
        PFD_DOWN,
        PFD_BOTH
    } pfd_state_t;

    // Largest positive value of a signed number of the given width
    function automatic int err_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    // Most negative value of a signed number of the given width
    function automatic int err_min(input int width);
        return -(1 << (width - 1));
    endfunction

endpackage

// File: rtl/sampled_phase_frequency_detector_edge_synchronizer.sv
// Synchronises one asynchronous clock input into the clk domain and flags
// its rising edges. The history flop is held at 1 until the reset zeros have
// been flushed out of the chain, so an input that was already high while in
// reset never looks like a fresh 0->1 transition.
module edge_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic [SYNC_STAGES-1:0] flush_chain;
    logic                   hist;

    // Synchronizer shift chain, flush tracker and history flop
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_chain  <= '0;
            flush_chain <= '0;
            hist        <= 1'b1;
        end else begin
            sync_chain  <= (sync_chain << 1) | SYNC_STAGES'(async_in);
            flush_chain <= (flush_chain << 1) | SYNC_STAGES'(1'b1);
            hist        <= flush_chain[SYNC_STAGES-1] ? sync_chain[SYNC_STAGES-1] : 1'b1;
        end
    end

    assign rise = sync_chain[SYNC_STAGES-1] & ~hist;

endmodule

// File: rtl/sampled_phase_frequency_detector.sv
// Sampled phase-frequency detector: Moore FSM driving charge-pump UP/DOWN with
// a fixed overlap pulse, a saturating signed phase-error measurement and a
// lock detector counting consecutive in-window comparisons.
module sampled_phase_frequency_detector
    import pll_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int MIN_ON_CYCLES = 1,
    parameter int ERR_WIDTH     = 8,
    parameter int LOCK_TOL      = 2,
    parameter int LOCK_COUNT    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        input_reference_clock_digital,
    input  logic                        input_feedback_clock_digital,
    output logic                        output_up_digital,
    output logic                        output_down_digital,
    output logic signed [ERR_WIDTH-1:0] phase_error,
    output logic                        phase_error_valid,
    output logic                        lock
);

    localparam int RUN_WIDTH = $clog2(LOCK_COUNT + 1);
    localparam int OVL_WIDTH = $clog2(MIN_ON_CYCLES + 1);

    localparam logic signed [ERR_WIDTH-1:0] ERR_MAX  = ERR_WIDTH'(err_max(ERR_WIDTH));
    localparam logic signed [ERR_WIDTH-1:0] ERR_MIN  = ERR_WIDTH'(err_min(ERR_WIDTH));
    localparam logic        [RUN_WIDTH-1:0] RUN_FULL = RUN_WIDTH'(LOCK_COUNT);
    localparam logic        [OVL_WIDTH-1:0] OVL_LAST = OVL_WIDTH'(MIN_ON_CYCLES - 1);
    localparam logic        [ERR_WIDTH:0]   TOL_MAG  = (ERR_WIDTH + 1)'(LOCK_TOL);

    logic ref_rise;
    logic fb_rise;

    pfd_state_t state;
    pfd_state_t next_state;
    logic       enter_both;

    logic        [OVL_WIDTH-1:0] ovl_cnt;
    logic signed [ERR_WIDTH-1:0] acc;
    logic        [RUN_WIDTH-1:0] run_cnt;
    logic        [ERR_WIDTH:0]   pe_ext;
    logic        [ERR_WIDTH:0]   pe_mag;

    edge_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (input_reference_clock_digital),
        .rise     (ref_rise)
    );

    edge_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (input_feedback_clock_digital),
        .rise     (fb_rise)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PFD_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; edges arriving in BOTH, or repeats of the leading edge, are dropped
    always_comb begin
        next_state = state;
        unique case (state)
            PFD_IDLE: begin
                if (ref_rise && fb_rise) begin
                    next_state = PFD_BOTH;
                end else if (ref_rise) begin
                    next_state = PFD_UP;
                end else if (fb_rise) begin
                    next_state = PFD_DOWN;
                end
            end
            PFD_UP: begin
                if (fb_rise) begin
                    next_state = PFD_BOTH;
                end
            end
            PFD_DOWN: begin
                if (ref_rise) begin
                    next_state = PFD_BOTH;
                end
            end
            PFD_BOTH: begin
                if (ovl_cnt == OVL_LAST) begin
                    next_state = PFD_IDLE;
                end
            end
        endcase
        if (!enable) begin
            next_state = PFD_IDLE;
        end
    end

    assign enter_both = (next_state == PFD_BOTH) && (state != PFD_BOTH);

    assign output_up_digital   = (state == PFD_UP)   || (state == PFD_BOTH);
    assign output_down_digital = (state == PFD_DOWN) || (state == PFD_BOTH);

    // Overlap counter, error accumulator and the registered comparison result
    always_ff @(posedge clk) begin
        if (reset) begin
            ovl_cnt           <= '0;
            acc               <= '0;
            phase_error       <= '0;
            phase_error_valid <= 1'b0;
        end else begin
            ovl_cnt           <= (state == PFD_BOTH && next_state == PFD_BOTH) ?
                                 ovl_cnt + 1'b1 : '0;
            phase_error_valid <= enter_both;
            if (!enable) begin
                acc <= '0;
            end else if (state == PFD_IDLE && next_state == PFD_UP) begin
                acc <= ERR_WIDTH'(1);
            end else if (state == PFD_IDLE && next_state == PFD_DOWN) begin
                acc <= -ERR_WIDTH'(1);
            end else if (state == PFD_IDLE && next_state == PFD_BOTH) begin
                acc <= '0;
            end else if (state == PFD_UP && next_state == PFD_UP) begin
                acc <= (acc == ERR_MAX) ? acc : acc + ERR_WIDTH'(1);
            end else if (state == PFD_DOWN && next_state == PFD_DOWN) begin
                acc <= (acc == ERR_MIN) ? acc : acc - ERR_WIDTH'(1);
            end
            if (enter_both) begin
                phase_error <= (state == PFD_IDLE) ? '0 : acc;
            end
        end
    end

    assign pe_ext = {phase_error[ERR_WIDTH-1], phase_error};
    assign pe_mag = pe_ext[ERR_WIDTH] ? (~pe_ext + 1'b1) : pe_ext;

    // Consecutive in-lock comparison counter
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt <= '0;
        end else if (!enable) begin
            run_cnt <= '0;
        end else if (phase_error_valid) begin
            if (pe_mag <= TOL_MAG) begin
                if (run_cnt != RUN_FULL) begin
                    run_cnt <= run_cnt + 1'b1;
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

    assign lock = (run_cnt == RUN_FULL);

endmodule

// File: tb/tb_sampled_phase_frequency_detector.sv
// Scoreboard bench for the sampled phase-frequency detector.
module tb_sampled_phase_frequency_detector;

    localparam int MIN_ON = 2;

    typedef struct {
        logic signed [7:0] pe;
        int                up_cnt;
        int                dn_cnt;
        logic              lk;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              ref_clk;
    logic              fb_clk;
    logic              up;
    logic              dn;
    logic signed [7:0] phase_error;
    logic              phase_error_valid;
    logic              lock;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   up_alone;
    int   dn_alone;
    int   both_len;
    logic lock_pending;
    logic pending_lk;
    logic prev_valid;

    sampled_phase_frequency_detector #(
        .SYNC_STAGES   (2),
        .MIN_ON_CYCLES (MIN_ON),
        .ERR_WIDTH     (8),
        .LOCK_TOL      (2),
        .LOCK_COUNT    (4)
    ) dut (
        .clk                           (clk),
        .reset                         (reset),
        .enable                        (enable),
        .input_reference_clock_digital (ref_clk),
        .input_feedback_clock_digital  (fb_clk),
        .output_up_digital             (up),
        .output_down_digital           (dn),
        .phase_error                   (phase_error),
        .phase_error_valid             (phase_error_valid),
        .lock                          (lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || lock_pending) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_timeout", (n >= 1000) ? 1 : 0, 0);
    endtask

    // One comparison: leader rises, follower rises gap cycles later
    task automatic applyStimulus(input bit ref_lead, input int gap,
                                 input logic signed [7:0] pe, input logic lk);
        exp_t e;
        e.pe     = pe;
        e.up_cnt = ref_lead ? gap : 0;
        e.dn_cnt = ref_lead ? 0 : gap;
        e.lk     = lk;
        exp_q.push_back(e);
        @(negedge clk);
        if (gap == 0) begin
            ref_clk = 1'b1;
            fb_clk  = 1'b1;
        end else begin
            if (ref_lead) ref_clk = 1'b1;
            else          fb_clk  = 1'b1;
            repeat (gap) @(negedge clk);
            ref_clk = 1'b1;
            fb_clk  = 1'b1;
        end
        waitDrain();
        repeat (4) @(negedge clk);
        ref_clk = 1'b0;
        fb_clk  = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on each valid pulse and checks overlap/lock timing
    always @(negedge clk) begin
        exp_t e;
        if (reset || !enable) begin
            up_alone   = 0;
            dn_alone   = 0;
            both_len   = 0;
            prev_valid = 1'b0;
        end else begin
            if (lock_pending) begin
                checkOutput("lock_after_valid", int'(lock), int'(pending_lk));
                lock_pending = 1'b0;
            end
            if (phase_error_valid) begin
                checkOutput("valid_single_pulse", int'(prev_valid), 0);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("phase_error", int'(phase_error), int'(e.pe));
                    checkOutput("up_alone_cycles", up_alone, e.up_cnt);
                    checkOutput("down_alone_cycles", dn_alone, e.dn_cnt);
                    pending_lk   = e.lk;
                    lock_pending = 1'b1;
                end
                up_alone = 0;
                dn_alone = 0;
            end
            if (up && !dn) up_alone++;
            if (dn && !up) dn_alone++;
            if (up && dn) begin
                both_len++;
            end else if (both_len != 0) begin
                checkOutput("overlap_cycles", both_len, MIN_ON);
                both_len = 0;
            end
            prev_valid = phase_error_valid;
        end
    end

    initial begin
        int activity;
        exp_t e;
        checks       = 0;
        errors       = 0;
        lock_pending = 1'b0;
        pending_lk   = 1'b0;
        up_alone     = 0;
        dn_alone     = 0;
        both_len     = 0;
        prev_valid   = 1'b0;
        reset        = 1'b1;
        enable       = 1'b1;
        ref_clk      = 1'b0;
        fb_clk       = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_up", int'(up), 0);
        checkOutput("reset_down", int'(dn), 0);
        checkOutput("reset_phase_error", int'(phase_error), 0);
        checkOutput("reset_valid", int'(phase_error_valid), 0);
        checkOutput("reset_lock", int'(lock), 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        $display("[TB] ref leads by 5");
        applyStimulus(1'b1, 5, 8'sd5, 1'b0);
        $display("[TB] fb leads by 3");
        applyStimulus(1'b0, 3, -8'sd3, 1'b0);
        $display("[TB] simultaneous edges");
        applyStimulus(1'b1, 0, 8'sd0, 1'b0);

        $display("[TB] long ref lead with extra ref edges, saturation");
        e.pe = 8'sd127; e.up_cnt = 300; e.dn_cnt = 0; e.lk = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        ref_clk = 1'b1;
        repeat (20) @(negedge clk);
        ref_clk = 1'b0;
        repeat (20) @(negedge clk);
        ref_clk = 1'b1;
        repeat (20) @(negedge clk);
        ref_clk = 1'b0;
        repeat (20) @(negedge clk);
        ref_clk = 1'b1;
        repeat (220) @(negedge clk);
        fb_clk = 1'b1;
        waitDrain();
        repeat (4) @(negedge clk);
        ref_clk = 1'b0;
        fb_clk  = 1'b0;
        repeat (6) @(negedge clk);

        $display("[TB] lock acquisition and loss");
        applyStimulus(1'b1, 1, 8'sd1, 1'b0);
        applyStimulus(1'b0, 2, -8'sd2, 1'b0);
        applyStimulus(1'b1, 0, 8'sd0, 1'b0);
        applyStimulus(1'b1, 2, 8'sd2, 1'b1);
        applyStimulus(1'b1, 3, 8'sd3, 1'b0);

        $display("[TB] enable drop mid-UP");
        @(negedge clk);
        ref_clk = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("enable_pre_up", int'(up), 1);
        enable = 1'b0;
        @(negedge clk);
        checkOutput("disabled_up", int'(up), 0);
        checkOutput("disabled_down", int'(dn), 0);
        fb_clk = 1'b1;
        repeat (8) @(negedge clk);
        enable = 1'b1;
        activity = 0;
        repeat (10) begin
            @(negedge clk);
            if (up || dn || phase_error_valid) activity++;
        end
        checkOutput("reenable_activity", activity, 0);
        ref_clk = 1'b0;
        fb_clk  = 1'b0;
        repeat (6) @(negedge clk);

        $display("[TB] reset mid-UP with inputs held high");
        @(negedge clk);
        ref_clk = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("reset_pre_up", int'(up), 1);
        fb_clk = 1'b1;
        reset  = 1'b1;
        @(negedge clk);
        checkOutput("midreset_up", int'(up), 0);
        checkOutput("midreset_down", int'(dn), 0);
        checkOutput("midreset_valid", int'(phase_error_valid), 0);
        checkOutput("midreset_phase_error", int'(phase_error), 0);
        checkOutput("midreset_lock", int'(lock), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        activity = 0;
        repeat (20) begin
            @(negedge clk);
            if (up || dn || phase_error_valid) activity++;
        end
        checkOutput("post_reset_activity", activity, 0);
        ref_clk = 1'b0;
        fb_clk  = 1'b0;
        repeat (6) @(negedge clk);
        applyStimulus(1'b1, 0, 8'sd0, 1'b0);

        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
